freq_gate_ctrl: RTL
===================

Name: freq_gate_ctrl

Overview:
- Measurement sequencer for the frequency counter. Synchronises the external signal and turns its rising edges into count-enable pulses for the cascaded bcdCount chain.
- Generates the clear / gate / latch sequence around a fixed gate window and captures the chain's BCD digits into a stable display register.
- Sits between the board input pin, the bcdCount chain and the seven-segment display driver.

Parameters:
- GATE_CYCLES, 100000000, gate window length in clk cycles (1 s at 100 MHz).
- DIGITS, 4, number of BCD digits in the counter chain.
- GW, 27, width of the internal gate timer; must satisfy 2^GW > GATE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  level; continuous measurement enabled while high.
- sig_in  input  1  asynchronous signal under measurement.
- bcd_in  input  4*DIGITS  live digits from the counter chain; digit 0 in [3:0].
- carry_in  input  1  carry out of the most significant chain digit.
- cnt_clr  output  1  synchronous clear to the chain.
- cnt_en  output  1  one-cycle count pulse per detected sig_in rising edge.
- freq_bcd  output  4*DIGITS  latched result of the last completed measurement.
- valid  output  1  one-cycle pulse when freq_bcd updates.
- ovf  output  1  last measurement overflowed the chain.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; gate timer=0; synchroniser flops=0.
  - All outputs 0, including freq_bcd and ovf.
- Input conditioning:
  - sig_in passes through 2 sync flops (s1, s2), then a history flop s3.
  - edge = s2 & ~s3.
  - A sig_in rise sampled at clk edge k produces edge high during cycle k+2.
- States: IDLE, CLEAR, GATE, LATCH.
  - IDLE: outputs idle, busy=0. run=1 -> CLEAR on the next clk.
  - CLEAR: exactly 1 cycle. cnt_clr=1, cnt_en=0, gate timer loaded with 0. Always -> GATE.
  - GATE: exactly GATE_CYCLES cycles; the timer increments each cycle.
    - cnt_en=edge.
    - Any cycle with carry_in=1 and cnt_en=1 sets the internal ovf_flag.
    - When timer==GATE_CYCLES-1 -> LATCH. Edges in that final cycle are still counted.
  - LATCH: exactly 1 cycle, cnt_en=0.
    - freq_bcd<=bcd_in; ovf<=ovf_flag; valid=1 for this one cycle.
    - Then run=1 -> CLEAR, run=0 -> IDLE.
- Edges arriving during CLEAR, LATCH or IDLE are dropped, not queued.
- Measurement period is GATE_CYCLES+2 cycles in continuous mode.
- run falling mid-measurement: the current gate and latch complete normally, then IDLE. No aborted measurement ever updates freq_bcd.
- freq_bcd and ovf hold their values between LATCH cycles and across IDLE.
- ovf_flag clears in CLEAR.
- Timer arithmetic: unsigned GW-bit counter, compared against GATE_CYCLES-1; it never wraps within a gate.
- sig_in rising every clk (> clk/2) is not resolvable. The count equals the detected edges only.

Optional Feature:
- FREQ_OVF_SAT_EN
  - Defined: if ovf_flag=1 at LATCH, freq_bcd is forced to all digits 4'd9 (display saturates at the maximum) and ovf=1.
  - Undefined: freq_bcd latches the wrapped bcd_in unchanged and ovf still reports the overflow.

Test Plan:
- Reset behaviour: reset=0 mid-GATE with cnt_en pulsing -> next cycle all outputs 0, state IDLE; release with run=1 -> cnt_clr high exactly 1 cycle after release.
- Basic count: GATE_CYCLES=20, DIGITS=2, run=1, sig_in toggling every 2 clk (rise every 4), chain model attached -> exactly 5 cnt_en pulses per gate; freq_bcd=8'h05 with a valid pulse every 22 cycles.
- Boundary edge: sig_in rise timed so edge lands on the final GATE cycle -> counted; a rise landing in LATCH -> not counted; freq_bcd differs by exactly 1 between the two cases.
- Stop mid-gate: run=0 at gate cycle 5 -> measurement completes, one valid pulse, then busy=0 and IDLE; freq_bcd holds.
- Overflow: DIGITS=1, GATE_CYCLES=40, 12 edges per gate:
  - with FREQ_OVF_SAT_EN -> freq_bcd=4'h9, ovf=1;
  - without -> freq_bcd=4'h2, ovf=1.
  - Next gate with 3 edges -> ovf=0, freq_bcd=4'h3.
- Idle: run=0, sig_in toggling -> cnt_en, cnt_clr and valid stay 0 indefinitely.

Source files
------------

// File: rtl/freq_gate_ctrl_if.sv
// Interface bundle for freq_gate_ctrl.
// master: the board/counter-chain side (drives run, sig_in, bcd_in, carry_in).
// slave:  the sequencer itself (drives clear/enable/result outputs).
//
// Signals:
//   run      level, continuous measurement while high
//   sig_in   asynchronous signal under measurement
//   bcd_in   live chain digits, digit 0 in [3:0]
//   carry_in carry out of the most significant chain digit
//   cnt_clr  synchronous clear to the chain
//   cnt_en   one-cycle count pulse per detected sig_in rising edge
//   freq_bcd latched result of the last completed measurement
//   valid    one-cycle pulse marking a result update
//   ovf      last measurement overflowed the chain
//   busy     sequencer not idle
interface freq_gate_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  run;
  logic                  sig_in;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  carry_in;
  logic                  cnt_clr;
  logic                  cnt_en;
  logic [4*DIGITS-1:0]   freq_bcd;
  logic                  valid;
  logic                  ovf;
  logic                  busy;

  modport master (
    output run, sig_in, bcd_in, carry_in,
    input  cnt_clr, cnt_en, freq_bcd, valid, ovf, busy
  );

  modport slave (
    input  run, sig_in, bcd_in, carry_in,
    output cnt_clr, cnt_en, freq_bcd, valid, ovf, busy
  );
endinterface

// File: rtl/freq_gate_ctrl.sv
// Purpose: frequency-counter sequencer; conditions sig_in into count pulses and runs clear/gate/latch.
// Latency: sig_in rise -> cnt_en after 2-3 clk; measurement period GATE_CYCLES+2 clk in continuous mode.
// Backpressure: none; edges outside the gate window are dropped, results are overwritten each LATCH.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    freq_gate_ctrl_if.slave (run, sig_in, bcd_in, carry_in in;
//          cnt_clr, cnt_en, freq_bcd, valid, ovf, busy out)
//
// Build option: FREQ_OVF_SAT_EN - when defined, an overflowed measurement
// displays all nines instead of the wrapped chain value. ovf is reported
// either way.
//
// The interface instance must be built with the same DIGITS as this module.
module freq_gate_ctrl #(
  parameter int GATE_CYCLES = 100000000,
  parameter int DIGITS      = 4,
  parameter int GW          = 27
) (
  input  logic            clk,
  input  logic            reset,
  freq_gate_ctrl_if.slave bus
);

  localparam int W = 4 * DIGITS;
  // Last timer value inside the gate window.
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    GATE  = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   timer_q, timer_d;

  // Two-flop synchroniser (s1, s2) plus history flop (s3).
  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic            s3_q, s3_d;

  logic            ovf_flag_q, ovf_flag_d;

  // Registered outputs.
  logic            cnt_clr_q,  cnt_clr_d;
  logic            cnt_en_q,   cnt_en_d;
  logic            valid_q,    valid_d;
  logic            busy_q,     busy_d;
  logic            ovf_q,      ovf_d;
  logic [W-1:0]    freq_bcd_q, freq_bcd_d;

  // The detected edge is s2 & ~s3. Since cnt_en is registered, it is
  // computed one cycle early from the values s2/s3 are about to take
  // (s1 and s2), paired with the state about to be entered. The result is
  // cnt_en == (s2 & ~s3) exactly in the cycles the FSM spends in GATE.
  logic            edge_next;

  always_comb begin
    s1_d       = bus.sig_in;
    s2_d       = s1_q;
    s3_d       = s2_q;
    edge_next  = s1_q & ~s2_q;

    state_d    = state_q;
    timer_d    = timer_q;
    ovf_flag_d = ovf_flag_q;
    freq_bcd_d = freq_bcd_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.run) begin
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        timer_d    = '0;
        ovf_flag_d = 1'b0;
        state_d    = GATE;
      end

      GATE: begin
        timer_d = timer_q + GW'(1);
        // carry_in only matters when the chain is actually stepping.
        if (cnt_en_q && bus.carry_in) begin
          ovf_flag_d = 1'b1;
        end
        if (timer_q == GATE_LAST) begin
          state_d = LATCH;
        end
      end

      LATCH: begin
        // bcd_in is sampled here rather than on entry so that a count pulse
        // issued in the final gate cycle has already reached the chain.
`ifdef FREQ_OVF_SAT_EN
        if (ovf_flag_q) begin
          freq_bcd_d = {DIGITS{4'd9}};
        end else begin
          freq_bcd_d = bus.bcd_in;
        end
`else
        freq_bcd_d = bus.bcd_in;
`endif
        ovf_d   = ovf_flag_q;
        // A run drop anywhere in the measurement only takes effect here,
        // so freq_bcd is only ever written by a complete gate.
        state_d = bus.run ? CLEAR : IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Output flops track the state being entered so they line up with it.
    cnt_clr_d = (state_d == CLEAR);
    cnt_en_d  = edge_next && (state_d == GATE);
    valid_d   = (state_d == LATCH);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      ovf_flag_q <= 1'b0;
      cnt_clr_q  <= 1'b0;
      cnt_en_q   <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      freq_bcd_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      ovf_flag_q <= ovf_flag_d;
      cnt_clr_q  <= cnt_clr_d;
      cnt_en_q   <= cnt_en_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      freq_bcd_q <= freq_bcd_d;
    end
  end

  assign bus.cnt_clr  = cnt_clr_q;
  assign bus.cnt_en   = cnt_en_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.ovf      = ovf_q;
  assign bus.freq_bcd = freq_bcd_q;

endmodule
